pixel_array_ctrl: RTL and testbench

PIXEL_ARRAY_CTRL -- requirements
Module: pixel_array_ctrl

---
 rtl/pixel_array_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pixel_array_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_ctrl.sv
// Pixel array sequencer: erase, expose, ramp-ADC convert, then row-by-row latch and stream.
// Optional macro PIXEL_ARRAY_CTRL_GRAY_EN selects a Gray-coded ramp counter with Gray-to-binary readout.
module pixel_array_ctrl #(
  parameter int unsigned PIXEL_ARRAY_HEIGHT = 2,
  parameter int unsigned PIXEL_ARRAY_WIDTH  = 2,
  parameter int unsigned ADC_BITS           = 8,
  parameter int unsigned ERASE_CYCLES       = 4,
  localparam int unsigned RowW = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
  localparam int unsigned ColW = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  START,
  input  logic [15:0]                           EXPOSE_TIME,
  input  logic [PIXEL_ARRAY_WIDTH*ADC_BITS-1:0] DATA_IN,
  input  logic                                  PIXEL_READY,
  output logic                                  ERASE,
  output logic                                  EXPOSE,
  output logic                                  CONVERT,
  output logic [ADC_BITS-1:0]                   COUNTER,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]         READ,
  output logic [ADC_BITS-1:0]                   PIXEL_OUT,
  output logic                                  PIXEL_VALID,
  output logic [RowW-1:0]                       ROW_IDX,
  output logic [ColW-1:0]                       COL_IDX,
  output logic                                  BUSY,
  output logic                                  FRAME_DONE
);

  typedef enum logic [2:0] {
    StIdle, StErase, StExpose, StConvert, StLatch, StStream, StDone
  } state_e;

  localparam logic [PIXEL_ARRAY_HEIGHT-1:0] RowOne   = PIXEL_ARRAY_HEIGHT'(1);
  localparam logic [RowW-1:0]               LastRow  = RowW'(PIXEL_ARRAY_HEIGHT - 1);
  localparam logic [ColW-1:0]               LastCol  = ColW'(PIXEL_ARRAY_WIDTH - 1);

  state_e              state_q;
  logic [31:0]         cnt_q;
  logic [15:0]         exp_q;
  logic [ADC_BITS-1:0] bin_q;
  logic [ADC_BITS-1:0] row_buf [PIXEL_ARRAY_WIDTH];
  logic [RowW-1:0]     row_nxt;
  logic [ColW-1:0]     col_nxt;

  function automatic logic [ADC_BITS-1:0] count_code(input logic [ADC_BITS-1:0] b);
`ifdef PIXEL_ARRAY_CTRL_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic logic [ADC_BITS-1:0] pixel_code(input logic [ADC_BITS-1:0] v);
`ifdef PIXEL_ARRAY_CTRL_GRAY_EN
    logic [ADC_BITS-1:0] r;
    r[ADC_BITS-1] = v[ADC_BITS-1];
    for (int i = int'(ADC_BITS) - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ v[i];
    end
    return r;
`else
    return v;
`endif
  endfunction

  always_comb begin
    row_nxt = ROW_IDX + 1'b1;
    col_nxt = COL_IDX + 1'b1;
  end

  // Row buffer is data-only storage; it needs no reset.
  always_ff @(posedge CLK) begin
    if (state_q == StLatch) begin
      for (int unsigned c = 0; c < PIXEL_ARRAY_WIDTH; c++) begin
        row_buf[c] <= DATA_IN[c*ADC_BITS +: ADC_BITS];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      exp_q       <= '0;
      bin_q       <= '0;
      ERASE       <= 1'b0;
      EXPOSE      <= 1'b0;
      CONVERT     <= 1'b0;
      COUNTER     <= '0;
      READ        <= '0;
      PIXEL_OUT   <= '0;
      PIXEL_VALID <= 1'b0;
      ROW_IDX     <= '0;
      COL_IDX     <= '0;
      BUSY        <= 1'b0;
      FRAME_DONE  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START) begin
            state_q <= StErase;
            ERASE   <= 1'b1;
            BUSY    <= 1'b1;
            cnt_q   <= ERASE_CYCLES - 32'd1;
            exp_q   <= (EXPOSE_TIME == 16'd0) ? 16'd1 : EXPOSE_TIME;
            ROW_IDX <= '0;
            COL_IDX <= '0;
          end
        end
        StErase: begin
          if (cnt_q == '0) begin
            state_q <= StExpose;
            ERASE   <= 1'b0;
            EXPOSE  <= 1'b1;
            cnt_q   <= {16'd0, exp_q - 16'd1};
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        StExpose: begin
          if (cnt_q == '0) begin
            state_q <= StConvert;
            EXPOSE  <= 1'b0;
            CONVERT <= 1'b1;
            bin_q   <= '0;
            COUNTER <= '0;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        StConvert: begin
          // bin_q all-ones marks the last ramp step.
          if (&bin_q) begin
            state_q <= StLatch;
            CONVERT <= 1'b0;
            COUNTER <= '0;
            READ    <= RowOne << ROW_IDX;
          end else begin
            bin_q   <= bin_q + 1'b1;
            COUNTER <= count_code(bin_q + 1'b1);
          end
        end
        StLatch: begin
          state_q     <= StStream;
          READ        <= '0;
          PIXEL_VALID <= 1'b1;
          COL_IDX     <= '0;
          PIXEL_OUT   <= pixel_code(DATA_IN[ADC_BITS-1:0]);
        end
        StStream: begin
          if (PIXEL_READY) begin
            if (COL_IDX == LastCol) begin
              PIXEL_VALID <= 1'b0;
              if (ROW_IDX == LastRow) begin
                state_q    <= StDone;
                FRAME_DONE <= 1'b1;
              end else begin
                state_q <= StLatch;
                ROW_IDX <= row_nxt;
                READ    <= RowOne << row_nxt;
              end
            end else begin
              COL_IDX   <= col_nxt;
              PIXEL_OUT <= pixel_code(row_buf[col_nxt]);
            end
          end
        end
        StDone: begin
          state_q    <= StIdle;
          FRAME_DONE <= 1'b0;
          BUSY       <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Bench for pixel_array_ctrl: timeline model checked every cycle plus directed literal checks.
module tb_pixel_array_ctrl;
  localparam int H  = 2;
  localparam int W  = 2;
  localparam int AB = 8;
  localparam int EC = 4;
  localparam int RW = 1;
  localparam int CW = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            ready = 1'b0;
  logic [15:0]     exp_time = 16'd0;
  logic [W*AB-1:0] data_in;
  logic            erase, expose, convert, pixel_valid, busy, frame_done;
  logic [AB-1:0]   counter, pixel_out;
  logic [H-1:0]    read;
  logic [RW-1:0]   row_idx;
  logic [CW-1:0]   col_idx;

  logic [AB-1:0] pix_bin [H][W] = '{'{8'h11, 8'h22}, '{8'h33, 8'h44}};
  int exp_pix [4] = '{'h11, 'h22, 'h33, 'h44};

  int n_cmp = 0;
  int n_bad = 0;

  // Monitors, only ever incremented; stimulus takes snapshots.
  int n_erase = 0, n_expose = 0, n_conv = 0, n_done = 0, n_busy = 0;
  int cnt_sum = 0;
  int xfer [$];
  int reads [$];

  // Model state
  bit m_ok = 0, m_active = 0;
  int m_t, m_x, m_row, m_col, m_mode;

  always #5 clk = ~clk;

  function automatic logic [AB-1:0] pix_enc(input logic [AB-1:0] b);
`ifdef PIXEL_ARRAY_CTRL_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic logic [AB-1:0] cnt_enc(input int c);
    logic [AB-1:0] b;
    b = AB'(c);
`ifdef PIXEL_ARRAY_CTRL_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Sensor column bus follows the selected row.
  assign data_in = read[1] ? {pix_enc(pix_bin[1][1]), pix_enc(pix_bin[1][0])}
                           : {pix_enc(pix_bin[0][1]), pix_enc(pix_bin[0][0])};

  pixel_array_ctrl #(
    .PIXEL_ARRAY_HEIGHT(H),
    .PIXEL_ARRAY_WIDTH (W),
    .ADC_BITS          (AB),
    .ERASE_CYCLES      (EC)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .START      (start),
    .EXPOSE_TIME(exp_time),
    .DATA_IN    (data_in),
    .PIXEL_READY(ready),
    .ERASE      (erase),
    .EXPOSE     (expose),
    .CONVERT    (convert),
    .COUNTER    (counter),
    .READ       (read),
    .PIXEL_OUT  (pixel_out),
    .PIXEL_VALID(pixel_valid),
    .ROW_IDX    (row_idx),
    .COL_IDX    (col_idx),
    .BUSY       (busy),
    .FRAME_DONE (frame_done)
  );

  // Compare process: check outputs against the model, log, then advance the model
  // with the inputs that the next rising edge will sample.
  initial begin
    logic [5:0]    e_ctl;
    logic [AB-1:0] e_cnt;
    logic [H-1:0]  e_read;
    bit            e_pre;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        e_pre  = m_active && m_mode == 0;
        e_ctl  = {e_pre && m_t <= EC,
                  e_pre && m_t > EC && m_t <= EC + m_x,
                  e_pre && m_t > EC + m_x,
                  m_active,
                  m_active && m_mode == 3,
                  m_active && m_mode == 2};
        e_cnt  = (e_pre && m_t > EC + m_x) ? cnt_enc(m_t - EC - m_x - 1) : '0;
        e_read = (m_active && m_mode == 1) ? H'(1 << m_row) : '0;
        n_cmp++;
        if ({erase, expose, convert, busy, frame_done, pixel_valid, read, counter}
            !== {e_ctl, e_read, e_cnt}) begin
          n_bad++;
          $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time,
                   {erase, expose, convert, busy, frame_done, pixel_valid, read, counter},
                   {e_ctl, e_read, e_cnt});
        end
        if (m_active && m_mode == 2) begin
          n_cmp++;
          if ({pixel_out, row_idx, col_idx} !==
              {pix_bin[m_row][m_col], RW'(m_row), CW'(m_col)}) begin
            n_bad++;
            $display("FAIL cycle_pixel t=%0t got=%h want=%h", $time,
                     {pixel_out, row_idx, col_idx},
                     {pix_bin[m_row][m_col], RW'(m_row), CW'(m_col)});
          end
        end
      end
      if (erase === 1'b1) n_erase++;
      if (expose === 1'b1) n_expose++;
      if (convert === 1'b1) begin
        n_conv++;
        cnt_sum += int'(counter);
      end
      if (frame_done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
      if (read !== '0) reads.push_back(int'(read));
      if (pixel_valid === 1'b1 && ready) xfer.push_back(int'(pixel_out));

      if (!rst_n) begin
        m_ok     = 1;
        m_active = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1;
          m_t      = 1;
          m_x      = (exp_time == 16'd0) ? 1 : int'(exp_time);
          m_mode   = 0;
          m_row    = 0;
          m_col    = 0;
        end
      end else begin
        case (m_mode)
          0: if (m_t == EC + m_x + 256) m_mode = 1; else m_t++;
          1: begin m_mode = 2; m_col = 0; end
          2: if (ready) begin
               if (m_col == W - 1) begin
                 if (m_row == H - 1) m_mode = 3;
                 else begin m_row++; m_mode = 1; end
               end else m_col++;
             end
          default: m_active = 0;
        endcase
      end
    end
  end

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] x);
    exp_time = x;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (frame_done !== 1'b1 && n < 2000) begin tick(); n++; end
    check(name, int'(frame_done), 1);
    tick();
    check({name, "_busy_low"}, int'(busy), 0);
  endtask

  task automatic wait_conv(input string name);
    int n = 0;
    while (convert !== 1'b1 && n < 1000) begin tick(); n++; end
    check(name, int'(convert), 1);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_ctl"}, int'({erase, expose, convert, busy, frame_done, pixel_valid}), 0);
    check({name, "_data"}, int'({counter, read, pixel_out, row_idx, col_idx}), 0);
  endtask

  task automatic check_xfers(input string name, input int base);
    check({name, "_count"}, xfer.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < xfer.size()) check({name, "_val"}, xfer[base+i], exp_pix[i]);
    end
  endtask

  initial begin
    int b_er, b_ex, b_cv, b_dn, b_sum, b_rd, b_xf, b_busy;
    rst_n = 1'b0;
    ready = 1'b1;
    repeat (3) tick();
    check_reset_state("reset");

    // Frame 1: START on the first edge out of reset, exposure 10, ready held high.
    b_er = n_erase; b_ex = n_expose; b_cv = n_conv; b_dn = n_done;
    b_sum = cnt_sum; b_rd = reads.size(); b_xf = xfer.size();
    rst_n = 1'b1;
    pulse_start(16'd10);
    check("first_start_busy", int'(busy), 1);
    check("first_start_erase", int'(erase), 1);
    wait_done("f1_done");
    check("f1_erase_cycles", n_erase - b_er, 4);
    check("f1_expose_cycles", n_expose - b_ex, 10);
    check("f1_convert_cycles", n_conv - b_cv, 256);
    check("f1_counter_sum", cnt_sum - b_sum, 32640);
    check("f1_done_pulses", n_done - b_dn, 1);
    check("f1_read_count", reads.size() - b_rd, 2);
    if (reads.size() - b_rd >= 2) begin
      check("f1_read_row0", reads[b_rd], 1);
      check("f1_read_row1", reads[b_rd+1], 2);
    end
    check_xfers("f1_pixels", b_xf);

    // Frame 2: back-pressure on column 1 of row 0 for 5 cycles.
    ready = 1'b0;
    b_xf = xfer.size();
    pulse_start(16'd3);
    begin
      int n = 0;
      while (pixel_valid !== 1'b1 && n < 1000) begin tick(); n++; end
    end
    check("f2_valid", int'(pixel_valid), 1);
    check("f2_col0", int'(pixel_out), 'h11);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_pixel", int'(pixel_out), 'h22);
      check("stall_row", int'(row_idx), 0);
      check("stall_col", int'(col_idx), 1);
      tick();
    end
    ready = 1'b1;
    wait_done("f2_done");
    check_xfers("f2_pixels", b_xf);

    // Frame 3: zero exposure and a START during CONVERT that must be ignored.
    b_ex = n_expose;
    pulse_start(16'd0);
    wait_conv("f3_conv");
    pulse_start(16'd7);
    wait_done("f3_done");
    check("f3_expose_cycles", n_expose - b_ex, 1);
    b_busy = n_busy;
    repeat (300) tick();
    check("f3_no_second_frame", n_busy - b_busy, 0);

    // Frame 4: reset mid-CONVERT, then a full frame.
    pulse_start(16'd5);
    wait_conv("f4_conv");
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    check_reset_state("mid_reset");
    b_cv = n_conv; b_xf = xfer.size(); b_dn = n_done;
    rst_n = 1'b1;
    pulse_start(16'd2);
    check("f4_restart_busy", int'(busy), 1);
    wait_done("f4_done");
    check("f4_convert_cycles", n_conv - b_cv, 256);
    check("f4_done_pulses", n_done - b_dn, 1);
    check_xfers("f4_pixels", b_xf);

    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule
